// File: rtl/cache_pkg.sv
// Shared line geometry, controller states and the byte-lane merge helper for the cache.
package cache_pkg;
   localparam int BURST_BEATS = 4;
   localparam int LINE_WORDS  = 8;
   localparam int OFFSET_W    = 5;
   localparam int WORD_SEL_W  = $clog2(LINE_WORDS);
   localparam int BEAT_SEL_W  = $clog2(BURST_BEATS);

   typedef enum logic [2:0] {
      IDLE,
      WB,
      RD_CMD,
      RD_WAIT,
      COMPLETE
   } cache_state_t;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  mask);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction
endpackage

// File: rtl/cache_line_store.sv
// Per-line valid/dirty/tag state plus the line data array, with byte-lane word
// writes from the CPU side and 64-bit beat writes from refills.
module cache_line_store
   import cache_pkg::*;
#(
   parameter int INDEX_W = 1,
   parameter int TAG_W   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_W-1:0]    index,
   output logic                  line_valid,
   output logic                  line_dirty,
   output logic [TAG_W-1:0]      line_tag,
   input  logic [WORD_SEL_W-1:0] word_sel,
   output logic [31:0]           rd_word,
   input  logic [BEAT_SEL_W-1:0] beat_sel,
   output logic [63:0]           rd_beat,
   input  logic                  wr_en,
   input  logic [3:0]            wr_mask,
   input  logic [31:0]           wr_data,
   input  logic                  fill_en,
   input  logic [63:0]           fill_data,
   input  logic                  fill_done,
   input  logic [TAG_W-1:0]      fill_tag
);
   localparam int LINES = 1 << INDEX_W;

   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES*LINE_WORDS];

   assign line_valid = valid_q[index];
   assign line_dirty = dirty_q[index];
   assign line_tag   = tag_q[index];
   assign rd_word    = data_q[{index, word_sel}];
   assign rd_beat    = {data_q[{index, beat_sel, 1'b1}], data_q[{index, beat_sel, 1'b0}]};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_done) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
         end
         if (wr_en) dirty_q[index] <= 1'b1;
      end
   end

   // NOTE: tag and data arrays are deliberately not reset; the valid bits gate every use of them.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data_q[{index, beat_sel, 1'b0}] <= fill_data[31:0];
         data_q[{index, beat_sel, 1'b1}] <= fill_data[63:32];
      end
      if (wr_en) data_q[{index, word_sel}] <= merge_lanes(rd_word, wr_data, wr_mask);
      if (fill_done) tag_q[index] <= fill_tag;
   end
endmodule

// File: rtl/cache.sv
// Direct-mapped write-back, write-allocate cache between a 32-bit load/store port
// and a 4-beat x 64-bit burst RAM controller.
module cache
   import cache_pkg::*;
#(
   parameter int LineIndexBitWidth = 1,
   parameter int RamDepthBitWidth  = 4,
   parameter int RamAddressingMode = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [3:0]                  write_enable,
   input  logic [31:0]                 address,
   input  logic [31:0]                 data_in,
   output logic [31:0]                 data_out,
   output logic                        data_out_ready,
   output logic                        busy,
   output logic                        br_cmd,
   output logic                        br_cmd_en,
   output logic [RamDepthBitWidth-1:0] br_addr,
   output logic [63:0]                 br_wr_data,
   output logic [7:0]                  br_data_mask,
   input  logic [63:0]                 br_rd_data,
   input  logic                        br_rd_data_valid
);
   localparam int RAM_BYTE_W = RamDepthBitWidth + RamAddressingMode;
   localparam int TAG_W      = RAM_BYTE_W - OFFSET_W - LineIndexBitWidth;

   cache_state_t                 state_q, state_d;
   logic [BEAT_SEL_W-1:0]        beat_q, beat_d;
   logic [WORD_SEL_W-1:0]        lat_word;
   logic [LineIndexBitWidth-1:0] lat_index;
   logic [TAG_W-1:0]             lat_tag;
   logic [31:0]                  lat_data;
   logic [3:0]                   lat_mask;

   logic [WORD_SEL_W-1:0]        req_word, acc_word;
   logic [LineIndexBitWidth-1:0] req_index, acc_index;
   logic [TAG_W-1:0]             req_tag, line_tag;
   logic [31:0]                  acc_data, rd_word;
   logic [3:0]                   acc_mask;
   logic [BEAT_SEL_W-1:0]        beat_sel;
   logic [63:0]                  rd_beat;
   logic                         in_idle, line_valid, line_dirty, hit;
   logic                         do_access, latch_req, issue_wb, wb_next, issue_rd;
   logic                         fill_en, fill_done;

   wire unused_addr_bits = ^{address[31:RAM_BYTE_W], address[1:0]};

   assign req_word  = address[4:2];
   assign req_index = address[OFFSET_W +: LineIndexBitWidth];
   assign req_tag   = address[RAM_BYTE_W-1 -: TAG_W];

   // Outside IDLE the store is addressed by the latched miss request.
   assign in_idle   = (state_q == IDLE);
   assign acc_word  = in_idle ? req_word     : lat_word;
   assign acc_index = in_idle ? req_index    : lat_index;
   assign acc_mask  = in_idle ? write_enable : lat_mask;
   assign acc_data  = in_idle ? data_in      : lat_data;
   assign beat_sel  = in_idle ? '0           : beat_q;
   assign hit       = line_valid && (line_tag == req_tag);

   assign br_data_mask = '0;

   cache_line_store #(
      .INDEX_W (LineIndexBitWidth),
      .TAG_W   (TAG_W)
   ) u_store (
      .clk        (clk),
      .rst_n      (rst_n),
      .index      (acc_index),
      .line_valid (line_valid),
      .line_dirty (line_dirty),
      .line_tag   (line_tag),
      .word_sel   (acc_word),
      .rd_word    (rd_word),
      .beat_sel   (beat_sel),
      .rd_beat    (rd_beat),
      .wr_en      (do_access && (acc_mask != 4'd0)),
      .wr_mask    (acc_mask),
      .wr_data    (acc_data),
      .fill_en    (fill_en),
      .fill_data  (br_rd_data),
      .fill_done  (fill_done),
      .fill_tag   (lat_tag)
   );

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      do_access = 1'b0;
      latch_req = 1'b0;
      issue_wb  = 1'b0;
      wb_next   = 1'b0;
      issue_rd  = 1'b0;
      fill_en   = 1'b0;
      fill_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable) begin
               if (hit) begin
                  do_access = 1'b1;
               end else begin
                  latch_req = 1'b1;
                  if (line_valid && line_dirty) begin
                     issue_wb = 1'b1;
                     beat_d   = beat_q + BEAT_SEL_W'(1);
                     state_d  = WB;
                  end else begin
                     state_d  = RD_CMD;
                  end
               end
            end
         end
         WB: begin
            wb_next = 1'b1;
            beat_d  = beat_q + BEAT_SEL_W'(1);
            if (beat_q == BEAT_SEL_W'(BURST_BEATS - 1)) state_d = RD_CMD;
         end
         RD_CMD: begin
            issue_rd = 1'b1;
            state_d  = RD_WAIT;
         end
         RD_WAIT: begin
            if (br_rd_data_valid) begin
               fill_en = 1'b1;
               beat_d  = beat_q + BEAT_SEL_W'(1);
               if (beat_q == BEAT_SEL_W'(BURST_BEATS - 1)) begin
                  fill_done = 1'b1;
                  state_d   = COMPLETE;
               end
            end
         end
         COMPLETE: begin
            do_access = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         beat_q         <= '0;
         lat_word       <= '0;
         lat_index      <= '0;
         lat_tag        <= '0;
         lat_data       <= '0;
         lat_mask       <= '0;
         busy           <= 1'b0;
         data_out       <= '0;
         data_out_ready <= 1'b0;
         br_cmd_en      <= 1'b0;
         br_cmd         <= 1'b0;
         br_addr        <= '0;
         br_wr_data     <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         br_cmd_en <= 1'b0;
         if (in_idle) data_out_ready <= 1'b0;
         if (do_access) begin
            data_out_ready <= (acc_mask == 4'd0);
            if (acc_mask == 4'd0) data_out <= rd_word;
         end
         if (latch_req) begin
            lat_word  <= req_word;
            lat_index <= req_index;
            lat_tag   <= req_tag;
            lat_data  <= data_in;
            lat_mask  <= write_enable;
            busy      <= 1'b1;
         end
         if (state_q == COMPLETE) busy <= 1'b0;
         if (issue_wb) begin
            br_cmd_en  <= 1'b1;
            br_cmd     <= 1'b1;
            br_addr    <= {line_tag, acc_index, {BEAT_SEL_W{1'b0}}};
            br_wr_data <= rd_beat;
         end
         if (wb_next) br_wr_data <= rd_beat;
         if (issue_rd) begin
            br_cmd_en <= 1'b1;
            br_cmd    <= 1'b0;
            br_addr   <= {lat_tag, lat_index, {BEAT_SEL_W{1'b0}}};
         end
      end
   end
endmodule

// File: tb/tb_cache.sv
// Directed bench for the cache: a 16 x 64-bit burst RAM responder plus one task per scenario.
module tb_cache;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [3:0]  write_enable;
   logic [31:0] address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic        busy;
   logic        br_cmd;
   logic        br_cmd_en;
   logic [3:0]  br_addr;
   logic [63:0] br_wr_data;
   logic [7:0]  br_data_mask;
   logic [63:0] br_rd_data = '0;
   logic        br_rd_data_valid = 1'b0;

   int checks = 0;
   int failures = 0;

   cache dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .write_enable     (write_enable),
      .address          (address),
      .data_in          (data_in),
      .data_out         (data_out),
      .data_out_ready   (data_out_ready),
      .busy             (busy),
      .br_cmd           (br_cmd),
      .br_cmd_en        (br_cmd_en),
      .br_addr          (br_addr),
      .br_wr_data       (br_wr_data),
      .br_data_mask     (br_data_mask),
      .br_rd_data       (br_rd_data),
      .br_rd_data_valid (br_rd_data_valid)
   );

   always #5 clk = ~clk;

   // Burst RAM responder: 4-beat writes on consecutive cycles, read data 6 cycles after the command.
   logic [63:0] ram [16];
   logic        ram_ready = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [3:0]  rd_addr = '0;
   logic [3:0]  wb_addr = '0;
   int          wr_left = 0;
   int          rd_wait = 0;
   int          cyc = 0;
   int          wb_cyc = 0;
   int          rd_cyc = 0;
   int          wb_count = 0;
   int          protocol_err = 0;

   function automatic logic [63:0] image_word(input int i);
      case (i)
         1:       return 64'h9D8E2F17_AB4C3E6F;
         2:       return 64'h0F1E2D3C_D5B8A9C4;
         3:       return 64'h7D4E9F2C_11112222;
         4:       return 64'h55667788_2F5E3C7A;
         default: return {32'(i), 32'hC0DE0000 + 32'(i)};
      endcase
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      br_rd_data_valid <= 1'b0;
      if (!ram_ready) begin
         for (int i = 0; i < 16; i++) ram[i] <= image_word(i);
         ram_ready <= 1'b1;
      end else begin
         if (rd_wait != 0) begin
            rd_wait <= rd_wait - 1;
            if (rd_wait <= 4) begin
               br_rd_data_valid <= 1'b1;
               br_rd_data       <= ram[rd_addr + 4'(4 - rd_wait)];
            end
         end
         if (wr_left != 0) begin
            ram[wr_addr] <= br_wr_data;
            wr_addr      <= wr_addr + 4'd1;
            wr_left      <= wr_left - 1;
            if (br_cmd_en) protocol_err <= protocol_err + 1;
         end else if (br_cmd_en) begin
            if (br_cmd) begin
               ram[br_addr] <= br_wr_data;
               wr_addr      <= br_addr + 4'd1;
               wr_left      <= 3;
               wb_addr      <= br_addr;
               wb_cyc       <= cyc;
               wb_count     <= wb_count + 1;
            end else begin
               rd_addr <= br_addr;
               rd_wait <= 9;
               rd_cyc  <= cyc;
            end
         end
      end
   end

   logic        r_missed, r_first_rdy, r_rdy;
   logic [31:0] r_data;

   // One request: present it for one edge, then follow a miss until busy drops (bounded).
   task automatic do_req(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
      int n;
      @(negedge clk);
      address = addr; write_enable = we; data_in = wd; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0; write_enable = 4'd0;
      r_missed    = busy;
      r_first_rdy = data_out_ready;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL req_timeout addr=%h: busy=%b after %0d cycles, expected 0", addr, busy, n);
      end
      r_rdy  = data_out_ready;
      r_data = data_out;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; enable = 1'b0; write_enable = 4'd0; address = '0; data_in = '0;
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, data_out_ready, data_out} !== 34'd0) begin
         failures++;
         $display("FAIL reset_cpu_side: busy=%b ready=%b data_out=%h, expected all 0", busy, data_out_ready, data_out);
      end
      checks++;
      if ({br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask} !== 78'd0) begin
         failures++;
         $display("FAIL reset_ram_side: cmd_en=%b cmd=%b addr=%h wr=%h mask=%h, expected all 0",
                  br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || data_out_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy=%b ready=%b, expected 0 0", busy, data_out_ready);
      end
   endtask

   task automatic test_read_miss_hit();
      do_req(32'd16, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b1 || r_first_rdy !== 1'b0) begin
         failures++;
         $display("FAIL rd16_cold_miss: busy=%b ready=%b after first edge, expected 1 0", r_missed, r_first_rdy);
      end
      checks++;
      if (r_rdy !== 1'b1 || r_data !== 32'hD5B8A9C4) begin
         failures++;
         $display("FAIL rd16_data: ready=%b data=%h, expected 1 d5b8a9c4", r_rdy, r_data);
      end
      do_req(32'd8, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_rdy !== 1'b1 || r_data !== 32'hAB4C3E6F) begin
         failures++;
         $display("FAIL rd8_hit: busy=%b ready=%b data=%h, expected 0 1 ab4c3e6f", r_missed, r_rdy, r_data);
      end
   endtask

   task automatic test_second_line();
      do_req(32'd32, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b1 || r_first_rdy !== 1'b0) begin
         failures++;
         $display("FAIL rd32_miss: busy=%b ready=%b after first edge, expected 1 0", r_missed, r_first_rdy);
      end
      checks++;
      if (r_rdy !== 1'b1 || r_data !== 32'h2F5E3C7A) begin
         failures++;
         $display("FAIL rd32_data: ready=%b data=%h, expected 1 2f5e3c7a", r_rdy, r_data);
      end
      do_req(32'd12, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_data !== 32'h9D8E2F17) begin
         failures++;
         $display("FAIL rd12_hit: busy=%b data=%h, expected 0 9d8e2f17", r_missed, r_data);
      end
   endtask

   task automatic test_byte_lanes();
      logic [3:0]  masks [3];
      logic [31:0] wdata [3];
      logic [31:0] expv  [3];
      masks = '{4'b0001, 4'b0011, 4'b1100};
      wdata = '{32'h0000_00AD, 32'h0000_8765, 32'hFEEF_0000};
      expv  = '{32'hAB4C_3EAD, 32'hAB4C_8765, 32'hFEEF_8765};
      for (int i = 0; i < 3; i++) begin
         do_req(32'd8, masks[i], wdata[i]);
         checks++;
         if (r_missed !== 1'b0 || r_rdy !== 1'b0) begin
            failures++;
            $display("FAIL wr8_hit_%0d: busy=%b ready=%b, expected 0 0", i, r_missed, r_rdy);
         end
         do_req(32'd8, 4'd0, '0);
         checks++;
         if (r_rdy !== 1'b1 || r_data !== expv[i]) begin
            failures++;
            $display("FAIL wr8_readback_%0d: ready=%b data=%h, expected 1 %h", i, r_rdy, r_data, expv[i]);
         end
      end
   endtask

   task automatic test_dirty_evict();
      int wb_before;
      wb_before = wb_count;
      do_req(32'd64, 4'b1111, 32'hABCDEF12);
      checks++;
      if (r_missed !== 1'b1 || wb_count !== wb_before + 1 || wb_addr !== 4'd0) begin
         failures++;
         $display("FAIL evict_line0: busy=%b bursts=%0d addr=%h, expected 1 %0d 0", r_missed, wb_count, wb_addr, wb_before + 1);
      end
      checks++;
      if (ram[1] !== 64'h9D8E2F17_FEEF8765) begin
         failures++;
         $display("FAIL evict_beat1: ram[1]=%h, expected 9d8e2f17feef8765", ram[1]);
      end
      checks++;
      if (rd_cyc - wb_cyc !== 4) begin
         failures++;
         $display("FAIL rd_cmd_spacing: read command %0d cycles after write command, expected 4", rd_cyc - wb_cyc);
      end
      do_req(32'd64, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_data !== 32'hABCDEF12) begin
         failures++;
         $display("FAIL rd64_after_alloc: busy=%b data=%h, expected 0 abcdef12", r_missed, r_data);
      end
      do_req(32'd64, 4'b1111, 32'h1B2D3F42);
      do_req(32'd64, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_data !== 32'h1B2D3F42) begin
         failures++;
         $display("FAIL rd64_rewrite: busy=%b data=%h, expected 0 1b2d3f42", r_missed, r_data);
      end
   endtask

   task automatic test_writeback();
      do_req(32'd0, 4'b1111, 32'h0BADF00D);
      checks++;
      if (r_missed !== 1'b1 || wb_addr !== 4'd8 || ram[8][31:0] !== 32'h1B2D3F42) begin
         failures++;
         $display("FAIL wr0_evict_tag1: busy=%b wb_addr=%h ram[8]=%h, expected 1 8 ..1b2d3f42", r_missed, wb_addr, ram[8]);
      end
      do_req(32'd8, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_data !== 32'hFEEF8765) begin
         failures++;
         $display("FAIL rd8_after_wb: busy=%b data=%h, expected 0 feef8765", r_missed, r_data);
      end
      do_req(32'd28, 4'd0, '0);
      checks++;
      if (r_data !== 32'h7D4E9F2C) begin
         failures++;
         $display("FAIL rd28: data=%h, expected 7d4e9f2c", r_data);
      end
      do_req(32'd0, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b0 || r_data !== 32'h0BADF00D) begin
         failures++;
         $display("FAIL rd0_after_alloc: busy=%b data=%h, expected 0 0badf00d", r_missed, r_data);
      end
      checks++;
      if (protocol_err !== 0) begin
         failures++;
         $display("FAIL burst_protocol: %0d commands inside write bursts, expected 0", protocol_err);
      end
   endtask

   task automatic test_reset_mid_refill();
      @(negedge clk);
      address = 32'd96; write_enable = 4'd0; data_in = '0; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL refill_in_progress: busy=%b, expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, data_out_ready, data_out, br_cmd_en} !== 35'd0) begin
         failures++;
         $display("FAIL mid_reset: busy=%b ready=%b data_out=%h cmd_en=%b, expected all 0",
                  busy, data_out_ready, data_out, br_cmd_en);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      do_req(32'd32, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b1 || r_data !== 32'h2F5E3C7A) begin
         failures++;
         $display("FAIL rd32_refetch: busy=%b data=%h, expected 1 2f5e3c7a", r_missed, r_data);
      end
      do_req(32'd8, 4'd0, '0);
      checks++;
      if (r_missed !== 1'b1 || r_data !== 32'hFEEF8765) begin
         failures++;
         $display("FAIL rd8_refetch: busy=%b data=%h, expected 1 feef8765", r_missed, r_data);
      end
   endtask

   initial begin
      test_reset();
      test_read_miss_hit();
      test_second_line();
      test_byte_lanes();
      test_dirty_evict();
      test_writeback();
      test_reset_mid_refill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
